// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller in front of the iterative divider: accepts one divide,
// holds operands, pulses start, waits for ready (with timeout) and hands off to writeback.
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  output logic [31:0] div_opA,
  output logic [31:0] div_opB,
  output logic        div_start,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  input  logic        div_rdy,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_exception,
  output logic        wb_timeout,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      opa_nxt, opb_nxt, data_nxt;
  logic [4:0]       rd_nxt;
  logic             exc_nxt, to_nxt;

  // Next-state and datapath capture; flush keeps every latched value
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    opa_nxt   = div_opA;
    opb_nxt   = div_opB;
    rd_nxt    = wb_rd;
    data_nxt  = wb_data;
    exc_nxt   = wb_exception;
    to_nxt    = wb_timeout;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opa_nxt = req_opA;
            opb_nxt = req_opB;
            rd_nxt  = req_rd;
            if (req_opB == 32'd0) begin
              state_nxt = DONE;
              data_nxt  = 32'd0;
              exc_nxt   = 1'b1;
              to_nxt    = 1'b0;
            end else begin
              state_nxt = START;
            end
          end
        end
        START: begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
        WAIT: begin
          cnt_nxt = cnt + CNT_W'(1);
          // A ready seen on the first WAIT cycle may be left over from the previous run
          if ((cnt != '0) && div_rdy) begin
            state_nxt = DONE;
            data_nxt  = div_result;
            exc_nxt   = div_exception;
            to_nxt    = 1'b0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = DONE;
            data_nxt  = 32'd0;
            exc_nxt   = 1'b1;
            to_nxt    = 1'b1;
          end
        end
        DONE: begin
          if (wb_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and state-decoded handshake outputs, all registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      div_opA      <= 32'd0;
      div_opB      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_exception <= 1'b0;
      wb_timeout   <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      div_start    <= 1'b0;
      wb_valid     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      div_opA      <= opa_nxt;
      div_opB      <= opb_nxt;
      wb_rd        <= rd_nxt;
      wb_data      <= data_nxt;
      wb_exception <= exc_nxt;
      wb_timeout   <= to_nxt;
      req_ready    <= (state_nxt == IDLE);
      busy         <= (state_nxt != IDLE);
      div_start    <= (state_nxt == START);
      wb_valid     <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Issue/writeback controller directly upstream of the iterative divider.
- Accepts one divide request from the execute stage via a valid/ready handshake, holds the operands stable for the divider's whole run, and pulses the divider's start input.
- Waits for the divider's ready flag, then presents the result to writeback via a second valid/ready handshake.
- Provides the pipeline stall signal, a divide-by-zero short-circuit and a hang timeout.

Parameters:
- TIMEOUT, 40, maximum WAIT cycles before the operation is aborted as a fault.
- CNT_W, 6, width of the WAIT-cycle counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort from pipeline control.
- req_valid  in  1  execute stage presents a divide.
- req_ready  out  1  controller can accept a request.
- req_opA  in  32  dividend, signed.
- req_opB  in  32  divisor, signed.
- req_rd  in  5  destination register tag.
- div_opA  out  32  latched dividend to divider.
- div_opB  out  32  latched divisor to divider.
- div_start  out  1  one-cycle start pulse to divider (ctrl_DIV).
- div_result  in  32  divider quotient.
- div_exception  in  1  divider exception flag.
- div_rdy  in  1  divider result-ready flag.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  32  quotient.
- wb_rd  out  5  destination tag.
- wb_exception  out  1  divide-by-zero or timeout.
- wb_timeout  out  1  the abort was caused by a timeout.
- busy  out  1  stall request; high in every state except IDLE.

Behaviour:
- States: IDLE, START, WAIT, DONE. Reset (reset_n low, asynchronous) forces IDLE.
- Reset clears all registers to 0: div_opA, div_opB, wb_data, wb_rd, wb_exception, wb_timeout and the counter.
- During reset: div_start=0, wb_valid=0, busy=0, req_ready=1.
- req_ready = (state==IDLE). busy = !req_ready. div_start = (state==START). wb_valid = (state==DONE).
- IDLE: on req_valid, latch req_opA, req_opB and req_rd into div_opA, div_opB and wb_rd.
  - If req_opB==0: next state is DONE, wb_data=0, wb_exception=1, wb_timeout=0. The divider is never started.
  - Otherwise: next state is START.
- START: div_start high for exactly one cycle. Counter cleared. Next state is WAIT.
- WAIT: counter increments every cycle.
  - div_rdy is ignored while counter==0, so a stale ready flag from a previous operation cannot complete this one.
  - When counter>=1 and div_rdy=1: capture div_result into wb_data and div_exception into wb_exception, set wb_timeout=0, go to DONE.
  - Otherwise, when counter reaches TIMEOUT-1: set wb_data=0, wb_exception=1, wb_timeout=1, go to DONE.
  - A div_rdy in that same final cycle wins over the timeout.
- DONE: wb_valid held high. wb_data, wb_rd and wb_exception stay stable until wb_ready=1, then the next state is IDLE.
  - The controller does not accept a new request in the same cycle as the handoff; minimum request-to-request spacing is one IDLE cycle.
- div_opA and div_opB change only on IDLE acceptance. They are stable from START through DONE because the divider reads its operands combinationally for the whole run.
- flush=1 in any state: next state is IDLE, no div_start is issued and wb_valid drops.
  - Latched registers keep their values; no writeback occurs.
  - An orphaned divider run needs no cleanup, because the next start pulse reloads the divider.
- flush has priority over req_valid acceptance in IDLE.
- reset_n asserted mid-operation: immediate return to IDLE; outputs go to their reset values within the same cycle.
- Latency, request accepted at edge N:
  - div_start high during cycle N+1.
  - WAIT begins at N+2.
  - wb_valid rises one cycle after the sampled div_rdy.
  - Divide-by-zero: wb_valid high at cycle N+1.
- Arithmetic: no sign handling here; the divider owns it. The zero test is a full 32-bit compare on req_opB.

Test Plan:
- 100 / 7, behavioural divider with rdy after 33 cycles → exactly one div_start pulse; wb_data=14, wb_exception=0, wb_rd matches; busy high from acceptance to handoff.
- -100 / 7 then 0x80000000 / -1 back-to-back → wb_data=0xFFFFFFF2, then the divider's value passed through unchanged; second req_ready only after first handoff.
- 5 / 0 → no div_start; wb_valid at N+1, wb_data=0, wb_exception=1, wb_timeout=0.
- Divider holds div_rdy=1 from the prior op into the first WAIT cycle → ignored; completion only on the fresh rdy.
- wb_ready low for 3 cycles in DONE → wb_valid and wb_data stable across all 3 cycles; IDLE on the cycle after wb_ready.
- Stub divider never raises rdy, TIMEOUT=40 → DONE after 40 WAIT cycles with wb_exception=1, wb_timeout=1.
- Separately: flush in cycle 10 of WAIT → IDLE next cycle, no wb_valid.
- Separately: reset_n pulsed mid-WAIT → IDLE, all outputs at reset values.
